// File: rtl/wishbone_slave_regs.sv
// rtl/wishbone_slave_regs.sv - Wishbone register-file slave with optional wait states
// One request in flight; the response is registered and lasts exactly one cycle.
module wishbone_slave_regs #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   dat_mosi,
    output logic [DATA_W-1:0]   dat_miso,
    input  logic [DATA_W/8-1:0] sel,
    input  logic                we,
    input  logic                cyc,
    input  logic                stb,
    output logic                ack,
    output logic                err
);
    localparam int SEL_W = DATA_W / 8;
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    // Request seen by the decode: live bus when leaving IDLE, captured copy when leaving WAIT.
    logic [ADDR_W-1:0]   cur_adr;
    logic                cur_we;
    logic [SEL_W-1:0]    cur_sel;
    logic [DATA_W-1:0]   cur_dat;
    logic                enter_resp;
    logic                hit;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        cur_adr    = adr_q;
        cur_we     = we_q;
        cur_sel    = sel_q;
        cur_dat    = wdat_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cyc && stb) begin
                    adr_d   = adr;
                    we_d    = we;
                    sel_d   = sel;
                    wdat_d  = dat_mosi;
                    cur_adr = adr;
                    cur_we  = we;
                    cur_sel = sel;
                    cur_dat = dat_mosi;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_L;
                    end
                end
            end
            S_WAIT: begin
                if (!cyc) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        regs_d  = regs_q;
        hit     = 1'b0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_adr == ADDR_W'(i)) begin
                hit     = 1'b1;
                rd_word = regs_q[i];
                if (enter_resp && cur_we && !RO_MASK[i]) begin
                    for (int b = 0; b < SEL_W; b++) begin
                        if (cur_sel[b]) begin
                            regs_d[i][8*b +: 8] = cur_dat[8*b +: 8];
                        end
                    end
                end
            end
        end
        ack_d  = enter_resp && hit;
        err_d  = enter_resp && !hit;
        rdat_d = (enter_resp && hit && !cur_we) ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            regs_q  <= regs_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign dat_miso = rdat_q;
endmodule

// File: tb/tb_wishbone_slave_regs.sv
// tb/tb_wishbone_slave_regs.sv - bench for wishbone_slave_regs
// Instance 0: 12 regs, reg 2 read-only, no wait states. Instance 1: 16 regs, 3 wait states.
module tb_wishbone_slave_regs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  adr [2];
    logic [31:0] dat_mosi [2];
    logic [3:0]  sel [2];
    logic        we [2];
    logic        cyc [2];
    logic        stb [2];
    logic [31:0] miso0, miso1;
    logic        ack0, ack1, err0, err1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mregs [2][16];
    int          nregs [2] = '{12, 16};
    int          wsts [2]  = '{0, 3};
    logic [15:0] romask [2] = '{16'h0004, 16'h0000};

    wishbone_slave_regs #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(12), .WAIT_STATES(0),
                          .RO_MASK(12'h004)) dut0 (
        .clk(clk), .rst_n(rst_n), .adr(adr[0]), .dat_mosi(dat_mosi[0]), .dat_miso(miso0),
        .sel(sel[0]), .we(we[0]), .cyc(cyc[0]), .stb(stb[0]), .ack(ack0), .err(err0));

    wishbone_slave_regs #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(16), .WAIT_STATES(3),
                          .RO_MASK(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .adr(adr[1]), .dat_mosi(dat_mosi[1]), .dat_miso(miso1),
        .sel(sel[1]), .we(we[1]), .cyc(cyc[1]), .stb(stb[1]), .ack(ack1), .err(err1));

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? miso0 : miso1;
    endfunction

    task automatic model_xfer(input int d, input logic w, input logic [3:0] a,
                              input logic [31:0] wd, input logic [3:0] s,
                              output logic e_ack, output logic e_err, output logic [31:0] e_rd);
        e_rd = 32'h0;
        if (int'(a) >= nregs[d]) begin
            e_ack = 1'b0;
            e_err = 1'b1;
        end else begin
            e_ack = 1'b1;
            e_err = 1'b0;
            if (w) begin
                if (!romask[d][a]) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mregs[d][a][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                e_rd = mregs[d][a];
            end
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic o_ack, output logic o_err,
                        output logic [31:0] o_rd, output int lat, output logic after_bad);
        @(negedge clk);
        adr[d] = a; dat_mosi[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
        lat = -1; o_ack = 1'b0; o_err = 1'b0; o_rd = 32'h0; after_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (get_ack(d) || get_err(d)) begin
                o_ack = get_ack(d); o_err = get_err(d); o_rd = get_rd(d); lat = n;
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        if (lat > 0) begin
            @(posedge clk); #1;
            after_bad = get_ack(d) | get_err(d) | (get_rd(d) != 32'h0);
        end
    endtask

    task automatic test_reset();
        logic a_, e_, ab; logic [31:0] r; int l;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            adr[d] = '0; dat_mosi[d] = '0; sel[d] = '0; we[d] = 0; cyc[d] = 0; stb[d] = 0;
            for (int i = 0; i < 16; i++) mregs[d][i] = 32'h0;
        end
        #23;
        tests_run++;
        if ({ack0, err0, miso0, ack1, err1, miso1} !== 66'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ack0=%b err0=%b miso0=%h ack1=%b err1=%b miso1=%h, need all 0",
                     ack0, err0, miso0, ack1, err1, miso1);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, 4'(i), 32'h0, 4'hF, a_, e_, r, l, ab);
            tests_run++;
            if (a_ !== 1'b1 || r !== 32'h0 || l != 1) begin
                tests_failed++;
                $display("FAIL reset_read%0d: got ack=%b data=%h lat=%0d, need ack=1 data=0 lat=1", i, a_, r, l);
            end
        end
    endtask

    task automatic test_directed();
        logic a_, e_, ab, ea, ee; logic [31:0] r, er; int l;
        xfer(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, a_, e_, r, l, ab);
        model_xfer(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, ea, ee, er);
        tests_run++;
        if (a_ !== 1'b1 || e_ !== 1'b0 || l != 1 || ab !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_adr3: got ack=%b err=%b lat=%0d after=%b, need 1 0 1 0", a_, e_, l, ab);
        end
        xfer(0, 1'b0, 4'd3, 32'h0, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b1 || r !== 32'hDEADBEEF || l != 1 || ab !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_adr3: got ack=%b data=%h lat=%0d after=%b, need 1 deadbeef 1 0", a_, r, l, ab);
        end
        xfer(0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, a_, e_, r, l, ab);
        model_xfer(0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, ea, ee, er);
        xfer(0, 1'b1, 4'd5, 32'h00000000, 4'h2, a_, e_, r, l, ab);
        model_xfer(0, 1'b1, 4'd5, 32'h00000000, 4'h2, ea, ee, er);
        xfer(0, 1'b0, 4'd5, 32'h0, 4'h0, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b1 || r !== 32'hFFFF00FF) begin
            tests_failed++;
            $display("FAIL byte_lane: got ack=%b data=%h, need ack=1 data=ffff00ff", a_, r);
        end
        xfer(0, 1'b1, 4'd2, 32'h12345678, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b1 || e_ !== 1'b0) begin
            tests_failed++;
            $display("FAIL ro_write_ack: got ack=%b err=%b, need ack=1 err=0", a_, e_);
        end
        xfer(0, 1'b0, 4'd2, 32'h0, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b1 || r !== 32'h0) begin
            tests_failed++;
            $display("FAIL ro_read: got ack=%b data=%h, need ack=1 data=0", a_, r);
        end
        xfer(0, 1'b1, 4'd13, 32'hCAFEF00D, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b0 || e_ !== 1'b1 || r !== 32'h0 || l != 1 || ab !== 1'b0) begin
            tests_failed++;
            $display("FAIL oob_write: got ack=%b err=%b data=%h lat=%0d after=%b, need 0 1 0 1 0", a_, e_, r, l, ab);
        end
        xfer(0, 1'b0, 4'd13, 32'h0, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b0 || e_ !== 1'b1 || r !== 32'h0 || ab !== 1'b0) begin
            tests_failed++;
            $display("FAIL oob_read: got ack=%b err=%b data=%h after=%b, need 0 1 0 0", a_, e_, r, ab);
        end
        for (int i = 0; i < 12; i += 5) begin
            xfer(0, 1'b0, 4'(i), 32'h0, 4'hF, a_, e_, r, l, ab);
            tests_run++;
            if (r !== mregs[0][i]) begin
                tests_failed++;
                $display("FAIL oob_no_change%0d: got %h, need %h", i, r, mregs[0][i]);
            end
        end
    endtask

    task automatic test_stb_only();
        logic a_, e_, ab; logic [31:0] r; int l; int hits = 0;
        @(negedge clk);
        adr[0] = 4'd4; dat_mosi[0] = $urandom | 32'h1; sel[0] = 4'hF; we[0] = 1'b1; stb[0] = 1'b1; cyc[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack0 || err0) hits++;
        end
        stb[0] = 1'b0; we[0] = 1'b0;
        tests_run++;
        if (hits != 0) begin
            tests_failed++;
            $display("FAIL stb_only_term: got %0d terminations, need 0", hits);
        end
        xfer(0, 1'b0, 4'd4, 32'h0, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (r !== mregs[0][4]) begin
            tests_failed++;
            $display("FAIL stb_only_data: got %h, need %h", r, mregs[0][4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pat; logic [31:0] first_rd;
        @(negedge clk);
        adr[0] = 4'd3; sel[0] = 4'hF; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        first_rd = 32'h0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            pat[n] = ack0;
            if (n == 0) first_rd = miso0;
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (pat !== 5'b10101) begin
            tests_failed++;
            $display("FAIL b2b_ack_pattern: got %b, need 10101", pat);
        end
        tests_run++;
        if (first_rd !== mregs[0][3]) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h, need %h", first_rd, mregs[0][3]);
        end
    endtask

    task automatic test_random();
        logic a_, e_, ab, ea, ee, w; logic [31:0] r, er, wd; logic [3:0] a, s; int l;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 40; k++) begin
                a  = 4'($urandom_range(0, 15));
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                s  = (k % 7 == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                xfer(d, w, a, wd, s, a_, e_, r, l, ab);
                model_xfer(d, w, a, wd, s, ea, ee, er);
                tests_run++;
                if (a_ !== ea || e_ !== ee || r !== er || l != wsts[d] + 1 || ab !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_d%0d_%0d: we=%b adr=%0d got ack=%b err=%b data=%h lat=%0d after=%b, need %b %b %h %0d 0",
                             d, k, w, a, a_, e_, r, l, ab, ea, ee, er, wsts[d] + 1);
                end
            end
        end
    endtask

    task automatic test_wait_abort();
        logic a_, e_, ab; logic [31:0] r; int l; int hits = 0;
        @(negedge clk);
        adr[1] = 4'd9; dat_mosi[1] = ~mregs[1][9]; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack1 || err1) hits++;
        end
        tests_run++;
        if (hits != 0) begin
            tests_failed++;
            $display("FAIL abort_term: got %0d terminations, need 0", hits);
        end
        xfer(1, 1'b0, 4'd9, 32'h0, 4'hF, a_, e_, r, l, ab);
        tests_run++;
        if (a_ !== 1'b1 || r !== mregs[1][9] || l != 4) begin
            tests_failed++;
            $display("FAIL abort_lost_write: got ack=%b data=%h lat=%0d, need 1 %h 4", a_, r, l, mregs[1][9]);
        end
    endtask

    task automatic test_reset_mid();
        logic a_, e_, ab; logic [31:0] r; int l; int hits = 0; logic sa;
        @(negedge clk);
        adr[0] = 4'd3; sel[0] = 4'hF; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        sa = ack0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (sa !== 1'b1 || ack0 !== 1'b0 || miso0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got ack_before=%b ack=%b data=%h, need 1 0 0", sa, ack0, miso0);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        adr[1] = 4'd1; dat_mosi[1] = 32'hA5A5A5A5; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack1 || err1 || ack0 || err0) hits++;
        end
        tests_run++;
        if (hits != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_term: got %0d terminations, need 0", hits);
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nregs[d]; i++) begin
                xfer(d, 1'b0, 4'(i), 32'h0, 4'hF, a_, e_, r, l, ab);
                tests_run++;
                if (a_ !== 1'b1 || r !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL reset_clear_d%0d_r%0d: got ack=%b data=%h, need ack=1 data=0", d, i, a_, r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stb_only();
        test_back_to_back();
        test_random();
        test_wait_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
